// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: handshake and operand/result bundle for multicycle_alu.
//   master: drives start_i, ALU_Operation_i, A_i, B_i; observes busy/done/result flags.
//   slave : the ALU side; drives busy_o, done_o, ALU_Result_o, Zero_o, illegal_o.
// Parameter WIDTH must match the ALU instance.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALU_Operation_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] ALU_Result_o;
  logic             Zero_o;
  logic             illegal_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  busy_o, done_o, ALU_Result_o, Zero_o, illegal_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output busy_o, done_o, ALU_Result_o, Zero_o, illegal_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: WIDTH-bit integer unit (RV32I ALU ops + RV32M mul/div).
//   Logic/shift/compare/add ops finish in one cycle. MUL/MULH use an iterative
//   shift-add multiplier, DIV/DIVU/REM/REMU a restoring divider; both take
//   WIDTH iteration edges plus one sign fix-up edge.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any op in flight without done_o
//   bus    multicycle_alu_if.slave: start_i/ALU_Operation_i/A_i/B_i in,
//          busy_o/done_o/ALU_Result_o/Zero_o/illegal_o out (all registered)
// Configuration:
//   MALU_DIV_EN  defined   -> divider datapath and DIV state are built.
//                undefined -> opcodes 1100-1111 finish in one cycle with
//                             result 0 and illegal_o.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input logic              clk,
  input logic              reset,
  multicycle_alu_if.slave  bus
);

`ifdef MALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  // Shared iterative datapath: acc = product high / partial remainder,
  // lo = multiplier then product low / dividend then quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             hi_sel_q, hi_sel_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
`ifdef MALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] div_val;
`endif

  logic [3:0]       op;
  logic [SHW-1:0]   shamt;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] alu_res;
  logic             fin, fin_ill;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;

  assign op    = bus.ALU_Operation_i;
  assign shamt = bus.B_i[SHW-1:0];

  // Only DIVU/REMU treat operands as unsigned; MUL low half is sign-agnostic.
  assign sgn   = !((op[3:2] == 2'b11) && op[0]);
  assign a_neg = sgn & bus.A_i[WIDTH-1];
  assign b_neg = sgn & bus.B_i[WIDTH-1];
  assign a_mag = a_neg ? (~bus.A_i + 1'b1) : bus.A_i;
  assign b_mag = b_neg ? (~bus.B_i + 1'b1) : bus.B_i;

  always_comb begin : single_cycle_ops
    alu_res = '0;
    case (op)
      4'b0000: alu_res = bus.A_i + bus.B_i;
      4'b0001: alu_res = bus.A_i - bus.B_i;
      4'b0010: alu_res = bus.A_i & bus.B_i;
      4'b0011: alu_res = bus.A_i | bus.B_i;
      4'b0100: alu_res = bus.A_i ^ bus.B_i;
      4'b0101: alu_res = bus.A_i << shamt;
      4'b0110: alu_res = bus.A_i >> shamt;
      4'b0111: alu_res = $signed(bus.A_i) >>> shamt;
      4'b1000: alu_res[0] = $signed(bus.A_i) < $signed(bus.B_i);
      4'b1001: alu_res[0] = bus.A_i < bus.B_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin : next_state
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    hi_sel_d  = hi_sel_q;
    cnt_d     = cnt_q;
    fin       = 1'b0;
    fin_ill   = 1'b0;
    fin_res   = '0;

    // Shift-add step: add multiplicand when multiplier LSB set, then shift
    // the {carry, acc, lo} triple right by one.
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    prod    = {acc_q, lo_q};
    if (neg_q) prod = ~prod + 1'b1;

`ifdef MALU_DIV_EN
    is_div_d = is_div_q;
    rem_sh   = {acc_q, lo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, opb_q};
    div_val  = hi_sel_q ? acc_q : lo_q;
    if (neg_q) div_val = ~div_val + 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (op == 4'b1010 || op == 4'b1011) begin
            state_d  = S_MUL;
            busy_d   = 1'b1;
            acc_d    = '0;
            lo_d     = a_mag;
            opb_d    = b_mag;
            neg_d    = a_neg ^ b_neg;
            hi_sel_d = op[0];
            cnt_d    = SHW'(WIDTH - 1);
`ifdef MALU_DIV_EN
            is_div_d = 1'b0;
`endif
          end else if (op[3:2] == 2'b11) begin
`ifdef MALU_DIV_EN
            if (bus.B_i == '0) begin
              fin     = 1'b1;
              fin_res = op[1] ? bus.A_i : '1;
            end else if (!op[0] && bus.A_i == MOST_NEG && bus.B_i == '1) begin
              fin     = 1'b1;
              fin_res = op[1] ? '0 : bus.A_i;
            end else begin
              state_d  = S_DIV;
              busy_d   = 1'b1;
              acc_d    = '0;
              lo_d     = a_mag;
              opb_d    = b_mag;
              // Remainder follows the dividend; quotient follows sign xor.
              neg_d    = op[1] ? a_neg : (a_neg ^ b_neg);
              hi_sel_d = op[1];
              cnt_d    = SHW'(WIDTH - 1);
              is_div_d = 1'b1;
            end
`else
            fin     = 1'b1;
            fin_res = '0;
            fin_ill = 1'b1;
`endif
          end else begin
            fin     = 1'b1;
            fin_res = alu_res;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - SHW'(1);
      end
`ifdef MALU_DIV_EN
      S_DIV: begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - SHW'(1);
      end
`endif
      S_DONE: begin
        fin     = 1'b1;
`ifdef MALU_DIV_EN
        if (is_div_q) fin_res = div_val;
        else          fin_res = hi_sel_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`else
        fin_res = hi_sel_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`endif
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (fin) begin
      result_d  = fin_res;
      zero_d    = (fin_res == '0);
      done_d    = 1'b1;
      illegal_d = fin_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      hi_sel_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef MALU_DIV_EN
      is_div_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      hi_sel_q  <= hi_sel_d;
      cnt_q     <= cnt_d;
`ifdef MALU_DIV_EN
      is_div_q  <= is_div_d;
`endif
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.illegal_o    = illegal_q;
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed + random stimulus for multicycle_alu (WIDTH=32).
// Expected results come from a behavioural model and are queued at issue;
// a negedge monitor pops and compares on every done_o pulse.
module tb_multicycle_alu;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  exp_t sb[$];

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sa, sb64, p;
    logic signed [W-1:0] as, bs;
    logic ovf;
    sa   = $signed(a);
    sb64 = $signed(b);
    p    = sa * sb64;
    as   = a;
    bs   = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    e.ill = 1'b0;
    e.res = '0;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a << b[4:0];
      4'd6:  e.res = a >> b[4:0];
      4'd7:  e.res = as >>> b[4:0];
      4'd8:  e.res = {31'b0, as < bs};
      4'd9:  e.res = {31'b0, a < b};
      4'd10: e.res = p[31:0];
      4'd11: e.res = p[63:32];
`ifdef MALU_DIV_EN
      4'd12: e.res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : as / bs;
      4'd13: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: e.res = (b == 0) ? a : ovf ? 32'h0 : as % bs;
      4'd15: e.res = (b == 0) ? a : a % b;
`else
      default: e.ill = 1'b1;
`endif
    endcase
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == 4'd10 || op == 4'd11) return 33;
`ifdef MALU_DIV_EN
    if (op >= 4'd12) begin
      if (b == 0) return 0;
      if (op == 4'd12 || op == 4'd14)
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 33;
    end
`endif
    return 0;
  endfunction

  // Scoreboard consumer: every done_o pulse must match the oldest request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done_o) begin
      if (sb.size() == 0) begin
        check("done_without_request", {63'b0, bus.done_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result",  {32'b0, bus.ALU_Result_o}, {32'b0, e.res});
        check("zero",    {63'b0, bus.Zero_o}, {63'b0, (e.res == 0)});
        check("illegal", {63'b0, bus.illegal_o}, {63'b0, e.ill});
        check("busy_at_done", {63'b0, bus.busy_o}, 64'd0);
      end
    end
  end

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, busy_n, lat;
    lat = exp_lat(op, a, b);
    bus.ALU_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
    bus.start_i = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 0;
    busy_n = 0;
    while (!bus.done_o && n < 200) begin
      if (bus.busy_o) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
  endtask

  initial begin
    int n;
    int done_seen;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    bus.start_i = 1'b0;
    bus.ALU_Operation_i = '0;
    bus.A_i = '0;
    bus.B_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    {63'b0, bus.busy_o}, 64'd0);
    check("rst_done",    {63'b0, bus.done_o}, 64'd0);
    check("rst_illegal", {63'b0, bus.illegal_o}, 64'd0);
    check("rst_result",  {32'b0, bus.ALU_Result_o}, 64'd0);
    check("rst_zero",    {63'b0, bus.Zero_o}, 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: ADD, single cycle, busy never asserted
    run_op("add", 4'd0, 32'd5, 32'd7);

    // 2: SUB then SRA accepted in the cycle done_o is high
    bus.ALU_Operation_i = 4'd1;
    bus.A_i = 32'd9;
    bus.B_i = 32'd9;
    bus.start_i = 1'b1;
    sb.push_back(model(4'd1, 32'd9, 32'd9));
    @(posedge clk); #1;
    check("sub_done", {63'b0, bus.done_o}, 64'd1);
    bus.ALU_Operation_i = 4'd7;
    bus.A_i = 32'h8000_0000;
    bus.B_i = 32'd4;
    sb.push_back(model(4'd7, 32'h8000_0000, 32'd4));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("sra_b2b_done", {63'b0, bus.done_o}, 64'd1);
    check("sra_value", {32'b0, bus.ALU_Result_o}, 64'h0000_0000_F800_0000);
    @(posedge clk); #1;

    // 3: MULH / MUL with mixed signs
    run_op("mulh", 4'd11, 32'hFFFF_FFFE, 32'd3);
    run_op("mul",  4'd10, 32'hFFFF_FFFE, 32'd3);
    run_op("mul_big", 4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("mulh_negneg", 4'd11, 32'h8000_0000, 32'h8000_0000);

`ifdef MALU_DIV_EN
    // 4: divider signs, divide by zero, overflow
    run_op("div",     4'd12, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",     4'd14, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_z",  4'd13, 32'd7, 32'd0);
    run_op("rem_z",   4'd14, 32'd7, 32'd0);
    run_op("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu",    4'd13, 32'hFFFF_FFFF, 32'd3);
    run_op("remu",    4'd15, 32'hFFFF_FFFF, 32'd10);
`else
    // 6: divider absent -> illegal, single cycle
    run_op("divu_ill", 4'd13, 32'd8, 32'd2);
    run_op("rem_ill",  4'd14, 32'd8, 32'd3);
`endif

    // 5a: start during MUL is ignored and does not disturb operands
    bus.ALU_Operation_i = 4'd10;
    bus.A_i = 32'd1234;
    bus.B_i = 32'd5678;
    bus.start_i = 1'b1;
    sb.push_back(model(4'd10, 32'd1234, 32'd5678));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.ALU_Operation_i = 4'd0;
    bus.A_i = 32'd1;
    bus.B_i = 32'd1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 5;
    while (!bus.done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("mul_ignored_start_latency", 64'(n), 64'd33);

    // 5b: reset mid-MULH aborts with no done_o
    bus.ALU_Operation_i = 4'd11;
    bus.A_i = 32'hFFFF_FFFE;
    bus.B_i = 32'd3;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy",   {63'b0, bus.busy_o}, 64'd0);
    check("abort_done",   {63'b0, bus.done_o}, 64'd0);
    check("abort_result", {32'b0, bus.ALU_Result_o}, 64'd0);
    check("abort_zero",   {63'b0, bus.Zero_o}, 64'd1);
    done_seen = 0;
    repeat (40) begin
      if (bus.done_o) done_seen++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Random mix over all opcodes, including zero divisors
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 6 == 0) ? 32'd0 : $urandom;
      run_op("rand", rop, ra, rb);
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
